// File: rtl/fwd_hazard_unit_pkg.sv
// Purpose : shared encodings and parameter defaults for the forwarding/hazard unit.
// Latency : n/a (constants and a constant function only).
// Backpr. : n/a.
package fwd_hazard_unit_pkg;

    // fwd_src value meaning "operand comes from the register file".
    localparam int FWD_RF      = 0;

    // Default ready stages: ALU results are usable from EX, load data from MEM.
    localparam int ALU_RDY_DEF = 0;
    localparam int LD_RDY_DEF  = 1;

    // Width of a fwd_src field: it must encode RF plus one code per tracked stage.
    function automatic int fwd_sel_w(input int nstage);
        return (nstage < 1) ? 1 : $clog2(nstage + 1);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Purpose : one source operand - youngest-producer match, readiness check and operand mux.
// Latency : purely combinational, same cycle as the ID inputs.
// Backpr. : none; a not-ready hit is reported on hazard_o for the parent to stall on.
// Ports   : rs_i/used_i describe the operand; tbl_*_i is the in-flight writer table
//           (entry 0 = EX); rf_data_i/stage_data_i are the candidate values;
//           opnd_o/fwd_src_o are the selection, hazard_o a not-ready hit, fwd_o a ready forward.
module hazard_match
    import fwd_hazard_unit_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int AW      = 5,
    parameter int NSTAGE  = 3,
    parameter int SW      = 2,
    parameter int ALU_RDY = ALU_RDY_DEF,
    parameter int LD_RDY  = LD_RDY_DEF
) (
    input  logic [AW-1:0]          rs_i,
    input  logic                   used_i,
    input  logic [NSTAGE-1:0]      tbl_v_i,
    input  logic [NSTAGE*AW-1:0]   tbl_rd_i,
    input  logic [NSTAGE-1:0]      tbl_ld_i,
    input  logic [XLEN-1:0]        rf_data_i,
    input  logic [NSTAGE*XLEN-1:0] stage_data_i,
    output logic [XLEN-1:0]        opnd_o,
    output logic [SW-1:0]          fwd_src_o,
    output logic                   hazard_o,
    output logic                   fwd_o
);

    logic            hit;
    int              hit_k;
    logic            hit_ld;
    logic [XLEN-1:0] hit_data;
    int              rdy_stage;

    always_comb begin
        hit      = 1'b0;
        hit_k    = 0;
        hit_ld   = 1'b0;
        hit_data = '0;
        // Scan oldest to youngest so the youngest matching entry overwrites the others.
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (tbl_v_i[k] && (tbl_rd_i[k*AW +: AW] == rs_i)) begin
                hit      = 1'b1;
                hit_k    = k;
                hit_ld   = tbl_ld_i[k];
                hit_data = stage_data_i[k*XLEN +: XLEN];
            end
        end
        // x0 and unread operands never forward, whatever the table holds.
        if (!used_i || (rs_i == '0)) begin
            hit = 1'b0;
        end
        rdy_stage = hit_ld ? LD_RDY : ALU_RDY;

        opnd_o    = rf_data_i;
        fwd_src_o = SW'(FWD_RF);
        hazard_o  = 1'b0;
        fwd_o     = 1'b0;
        if (hit) begin
            // The stage value is passed through even when not ready; it is simply unused then.
            opnd_o = hit_data;
            if (hit_k >= rdy_stage) begin
                fwd_src_o = SW'(hit_k + 1);
                fwd_o     = 1'b1;
            end else begin
                hazard_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Purpose : operand forwarding, load-use/memory-wait stall and bubble control between ID and ID/EX.
// Latency : selection/stall combinational in the ID cycle; writer table lags ID by one cycle.
// Backpr. : stall holds PC and IF/ID (mem_wait or unresolved hazard); bubble forces a NOP into ID/EX.
// Ports   : clk/rst (sync, active-low); id_* describe the ID instruction; rf_data/stage_data are
//           candidate values; mem_wait/flush are pipeline controls; opnd_data/fwd_src are the
//           selected operands; stall/bubble control; stall_cnt/fwd_cnt saturating perf counters.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int NSRC    = 2,
    parameter int NSTAGE  = 3,
    parameter int ALU_RDY = ALU_RDY_DEF,
    parameter int LD_RDY  = LD_RDY_DEF,
    parameter int CNTW    = 32,
    localparam int AW     = $clog2(NREG),
    localparam int SW     = fwd_sel_w(NSTAGE)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [NSRC*AW-1:0]     id_rs,
    input  logic [NSRC-1:0]        id_rs_used,
    input  logic [AW-1:0]          id_rd,
    input  logic                   id_reg_write,
    input  logic                   id_is_load,
    input  logic [NSRC*XLEN-1:0]   rf_data,
    input  logic [NSTAGE*XLEN-1:0] stage_data,
    input  logic                   mem_wait,
    input  logic                   flush,
    output logic [NSRC*XLEN-1:0]   opnd_data,
    output logic [NSRC*SW-1:0]     fwd_src,
    output logic                   stall,
    output logic                   bubble,
    output logic [CNTW-1:0]        stall_cnt,
    output logic [CNTW-1:0]        fwd_cnt
);

    localparam int CW1 = CNTW + 1;

    // In-flight writer table, entry k = instruction now in stage k.
    logic [NSTAGE-1:0]    v_q,  v_d;
    logic [NSTAGE*AW-1:0] rd_q, rd_d;
    logic [NSTAGE-1:0]    ld_q, ld_d;
    logic [CNTW-1:0]      stall_cnt_q, stall_cnt_d;
    logic [CNTW-1:0]      fwd_cnt_q,   fwd_cnt_d;

    logic [NSRC-1:0]      hazard;
    logic [NSRC-1:0]      fwd;
    logic                 accept;
    int                   n_fwd;
    logic [CNTW:0]        stall_sum;
    logic [CNTW:0]        fwd_sum;

    for (genvar s = 0; s < NSRC; s++) begin : g_src
        hazard_match #(
            .XLEN    (XLEN),
            .AW      (AW),
            .NSTAGE  (NSTAGE),
            .SW      (SW),
            .ALU_RDY (ALU_RDY),
            .LD_RDY  (LD_RDY)
        ) u_match (
            .rs_i         (id_rs[s*AW +: AW]),
            .used_i       (id_rs_used[s]),
            .tbl_v_i      (v_q),
            .tbl_rd_i     (rd_q),
            .tbl_ld_i     (ld_q),
            .rf_data_i    (rf_data[s*XLEN +: XLEN]),
            .stage_data_i (stage_data),
            .opnd_o       (opnd_data[s*XLEN +: XLEN]),
            .fwd_src_o    (fwd_src[s*SW +: SW]),
            .hazard_o     (hazard[s]),
            .fwd_o        (fwd[s])
        );
    end

    // A flushed instruction cannot stall: it is being killed anyway.
    assign stall  = mem_wait | (id_valid & ~flush & (|hazard));
    assign bubble = stall | flush;
    assign accept = id_valid & id_reg_write & (id_rd != '0) & ~stall & ~flush;

    always_comb begin
        v_d  = v_q;
        rd_d = rd_q;
        ld_d = ld_q;
        // During a memory wait the whole pipe is frozen, so the table must not advance.
        if (!mem_wait) begin
            for (int k = NSTAGE - 1; k >= 1; k--) begin
                v_d[k]          = v_q[k-1];
                rd_d[k*AW +: AW] = rd_q[(k-1)*AW +: AW];
                ld_d[k]         = ld_q[k-1];
            end
            v_d[0]       = accept;
            rd_d[AW-1:0] = accept ? id_rd : '0;
            ld_d[0]      = accept & id_is_load;
        end
    end

    always_comb begin
        n_fwd = 0;
        for (int s = 0; s < NSRC; s++) begin
            if (fwd[s]) begin
                n_fwd = n_fwd + 1;
            end
        end
        // Forwards only count when the instruction actually moves on.
        if (stall) begin
            n_fwd = 0;
        end
        stall_sum   = {1'b0, stall_cnt_q} + CW1'(stall);
        fwd_sum     = {1'b0, fwd_cnt_q} + CW1'(n_fwd);
        stall_cnt_d = stall_sum[CNTW] ? '1 : stall_sum[CNTW-1:0];
        fwd_cnt_d   = fwd_sum[CNTW]   ? '1 : fwd_sum[CNTW-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            v_q         <= '0;
            rd_q        <= '0;
            ld_q        <= '0;
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            v_q         <= v_d;
            rd_q        <= rd_d;
            ld_q        <= ld_d;
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Purpose : self-checking bench for fwd_hazard_unit with an in-bench reference model.
// Latency : model advanced once per posedge, outputs compared on every negedge.
// Backpr. : n/a.
module tb_fwd_hazard_unit;

    localparam int XLEN   = 32;
    localparam int AW     = 5;
    localparam int NSRC   = 2;
    localparam int NSTAGE = 3;
    localparam int SW     = 2;
    localparam int CNTW   = 4;
    localparam int CMAX   = 15;
    localparam int ALU_R  = 0;
    localparam int LD_R   = 1;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   id_valid;
    logic [NSRC*AW-1:0]     id_rs;
    logic [NSRC-1:0]        id_rs_used;
    logic [AW-1:0]          id_rd;
    logic                   id_reg_write;
    logic                   id_is_load;
    logic [NSRC*XLEN-1:0]   rf_data;
    logic [NSTAGE*XLEN-1:0] stage_data;
    logic                   mem_wait;
    logic                   flush;
    logic [NSRC*XLEN-1:0]   opnd_data;
    logic [NSRC*SW-1:0]     fwd_src;
    logic                   stall;
    logic                   bubble;
    logic [CNTW-1:0]        stall_cnt;
    logic [CNTW-1:0]        fwd_cnt;

    always #5 clk = ~clk;

    fwd_hazard_unit #(
        .XLEN(XLEN), .NREG(32), .NSRC(NSRC), .NSTAGE(NSTAGE),
        .ALU_RDY(ALU_R), .LD_RDY(LD_R), .CNTW(CNTW)
    ) dut (
        .clk(clk), .rst(rst_n), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_is_load(id_is_load), .rf_data(rf_data), .stage_data(stage_data),
        .mem_wait(mem_wait), .flush(flush), .opnd_data(opnd_data),
        .fwd_src(fwd_src), .stall(stall), .bubble(bubble),
        .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: list of in-flight writers by pipeline position.
    bit         mv  [NSTAGE];
    logic [4:0] mrd [NSTAGE];
    bit         mld [NSTAGE];
    int         m_stall_cnt;
    int         m_fwd_cnt;

    int          e_src  [NSRC];
    logic [31:0] e_data [NSRC];
    bit          e_haz  [NSRC];
    bit          e_fwd  [NSRC];
    bit          e_stall;
    bit          e_bubble;

    function automatic void model_comb();
        logic [4:0] rs;
        int found;
        int need;
        for (int s = 0; s < NSRC; s++) begin
            rs        = id_rs[s*AW +: AW];
            e_src[s]  = 0;
            e_data[s] = rf_data[s*XLEN +: XLEN];
            e_haz[s]  = 1'b0;
            e_fwd[s]  = 1'b0;
            if (id_rs_used[s] && rs != 5'd0) begin
                found = -1;
                for (int k = 0; k < NSTAGE; k++)
                    if (found < 0 && mv[k] && mrd[k] == rs) found = k;
                if (found >= 0) begin
                    e_data[s] = stage_data[found*XLEN +: XLEN];
                    need = mld[found] ? LD_R : ALU_R;
                    if (found >= need) begin
                        e_src[s] = found + 1;
                        e_fwd[s] = 1'b1;
                    end else begin
                        e_haz[s] = 1'b1;
                    end
                end
            end
        end
        e_stall  = mem_wait || (id_valid && !flush && (e_haz[0] || e_haz[1]));
        e_bubble = e_stall || flush;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare all outputs against the model, away from the active edge.
    task automatic sample();
        @(negedge clk);
        model_comb();
        for (int s = 0; s < NSRC; s++) begin
            check($sformatf("opnd%0d", s), 64'(opnd_data[s*XLEN +: XLEN]), 64'(e_data[s]));
            if (!e_haz[s])
                check($sformatf("src%0d", s), 64'(fwd_src[s*SW +: SW]), 64'(e_src[s]));
        end
        check("stall", 64'(stall), 64'(e_stall));
        check("bubble", 64'(bubble), 64'(e_bubble));
        check("stall_cnt", 64'(stall_cnt), 64'(m_stall_cnt));
        check("fwd_cnt", 64'(fwd_cnt), 64'(m_fwd_cnt));
    endtask

    // Advance the model across one rising edge, then let inputs change.
    task automatic adv();
        int nf;
        @(posedge clk);
        model_comb();
        if (!rst_n) begin
            for (int k = 0; k < NSTAGE; k++) begin
                mv[k] = 0; mrd[k] = 0; mld[k] = 0;
            end
            m_stall_cnt = 0;
            m_fwd_cnt   = 0;
        end else begin
            nf = e_stall ? 0 : (int'(e_fwd[0]) + int'(e_fwd[1]));
            if (e_stall) m_stall_cnt = (m_stall_cnt + 1 > CMAX) ? CMAX : m_stall_cnt + 1;
            m_fwd_cnt = (m_fwd_cnt + nf > CMAX) ? CMAX : m_fwd_cnt + nf;
            if (!mem_wait) begin
                for (int k = NSTAGE - 1; k >= 1; k--) begin
                    mv[k] = mv[k-1]; mrd[k] = mrd[k-1]; mld[k] = mld[k-1];
                end
                if (id_valid && id_reg_write && id_rd != 0 && !e_stall && !flush) begin
                    mv[0] = 1; mrd[0] = id_rd; mld[0] = id_is_load;
                end else begin
                    mv[0] = 0; mrd[0] = 0; mld[0] = 0;
                end
            end
        end
        #1;
    endtask

    task automatic set_id(input bit v, input int rs0, input int rs1, input int used,
                          input int rd, input bit rw, input bit ld);
        id_valid     = v;
        id_rs        = {AW'(rs1), AW'(rs0)};
        id_rs_used   = NSRC'(used);
        id_rd        = AW'(rd);
        id_reg_write = rw;
        id_is_load   = ld;
    endtask

    initial begin
        for (int k = 0; k < NSTAGE; k++) begin
            mv[k] = 0; mrd[k] = 0; mld[k] = 0;
        end
        m_stall_cnt = 0;
        m_fwd_cnt   = 0;
        rst_n      = 1'b0;
        mem_wait   = 1'b0;
        flush      = 1'b0;
        rf_data    = {32'h2222_2222, 32'h1111_1111};
        stage_data = {32'hBBBB, 32'h5555, 32'h1234};
        set_id(0, 0, 0, 0, 0, 0, 0);
        adv();
        adv();
        // Reset state
        rst_n = 1'b1;
        set_id(1, 5, 6, 3, 0, 0, 0);
        sample();
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_opnd0", 64'(opnd_data[31:0]), 64'h1111_1111);
        check("rst_src", 64'(fwd_src), 64'd0);
        check("rst_scnt", 64'(stall_cnt), 64'd0);
        adv();

        // 1: ALU back-to-back
        set_id(1, 0, 0, 0, 5, 1, 0);
        sample(); adv();
        set_id(1, 5, 0, 1, 0, 0, 0);
        sample();
        check("t1_src0", 64'(fwd_src[1:0]), 64'd1);
        check("t1_opnd0", 64'(opnd_data[31:0]), 64'h1234);
        check("t1_stall", 64'(stall), 64'd0);
        adv();

        // 2: load-use
        set_id(1, 0, 0, 0, 7, 1, 1);
        sample();
        check("t1_fcnt", 64'(fwd_cnt), 64'd1);
        adv();
        set_id(1, 0, 7, 2, 0, 0, 0);
        sample();
        check("t2_stall", 64'(stall), 64'd1);
        check("t2_bubble", 64'(bubble), 64'd1);
        adv();
        sample();
        check("t2_src1", 64'(fwd_src[3:2]), 64'd2);
        check("t2_opnd1", 64'(opnd_data[63:32]), 64'h5555);
        check("t2_stall2", 64'(stall), 64'd0);
        check("t2_scnt", 64'(stall_cnt), 64'd1);
        adv();

        // 3: duplicate rd, youngest wins; x0 never tracked
        stage_data = {32'hBBBB, 32'h5555, 32'hAAAA};
        set_id(1, 0, 0, 0, 3, 1, 0); sample(); adv();
        set_id(1, 0, 0, 0, 0, 1, 0); sample(); adv();
        set_id(1, 0, 0, 0, 3, 1, 0); sample(); adv();
        set_id(1, 3, 0, 3, 0, 0, 0);
        sample();
        check("t3_src0", 64'(fwd_src[1:0]), 64'd1);
        check("t3_opnd0", 64'(opnd_data[31:0]), 64'hAAAA);
        check("t3_src1", 64'(fwd_src[3:2]), 64'd0);
        check("t3_opnd1", 64'(opnd_data[63:32]), 64'h2222_2222);
        adv();

        // 4: mem_wait over a pending load-use, flush pulse ignored
        set_id(1, 0, 0, 0, 9, 1, 1); sample(); adv();
        set_id(1, 9, 0, 1, 0, 0, 0);
        mem_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            flush = (i == 1);
            sample();
            check("t4_stall", 64'(stall), 64'd1);
            adv();
        end
        mem_wait = 1'b0;
        flush    = 1'b0;
        sample();
        check("t4_scnt", 64'(stall_cnt), 64'd4);
        check("t4_lu_stall", 64'(stall), 64'd1);
        adv();
        sample();
        check("t4_src0", 64'(fwd_src[1:0]), 64'd2);
        check("t4_scnt2", 64'(stall_cnt), 64'd5);
        adv();

        // 5: flush beats the hazard stall
        set_id(1, 0, 0, 0, 12, 1, 1); sample(); adv();
        set_id(1, 12, 0, 1, 13, 1, 0);
        flush = 1'b1;
        sample();
        check("t5_stall", 64'(stall), 64'd0);
        check("t5_bubble", 64'(bubble), 64'd1);
        adv();
        flush = 1'b0;
        set_id(1, 13, 12, 3, 0, 0, 0);
        sample();
        check("t5_src0", 64'(fwd_src[1:0]), 64'd0);
        check("t5_src1", 64'(fwd_src[3:2]), 64'd2);
        check("t5_scnt", 64'(stall_cnt), 64'd5);
        adv();

        // 6: reset mid-stall, then counter saturation
        set_id(1, 0, 0, 0, 14, 1, 1); sample(); adv();
        set_id(1, 14, 0, 1, 0, 0, 0);
        sample();
        check("t6_stall", 64'(stall), 64'd1);
        rst_n = 1'b0;
        adv();
        rst_n = 1'b1;
        sample();
        check("t6_src0", 64'(fwd_src[1:0]), 64'd0);
        check("t6_opnd0", 64'(opnd_data[31:0]), 64'h1111_1111);
        check("t6_stall2", 64'(stall), 64'd0);
        check("t6_scnt", 64'(stall_cnt), 64'd0);
        check("t6_fcnt", 64'(fwd_cnt), 64'd0);
        adv();
        set_id(0, 0, 0, 0, 0, 0, 0);
        mem_wait = 1'b1;
        for (int i = 0; i < 17; i++) begin
            sample(); adv();
        end
        mem_wait = 1'b0;
        sample();
        check("t6_sat", 64'(stall_cnt), 64'hF);
        adv();

        // Mixed traffic against the model
        rst_n = 1'b0; adv(); rst_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            set_id(($urandom_range(0, 9) != 0), $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 1),
                   $urandom_range(0, 1));
            mem_wait   = ($urandom_range(0, 9) == 0);
            flush      = ($urandom_range(0, 9) == 0);
            rf_data    = {$urandom, $urandom};
            stage_data = {$urandom, $urandom, $urandom};
            sample();
            adv();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
